// File: rtl/bus_demux_8ch32_if.sv
// Bus bundle for the 8-channel demux: one input stream fanning out to eight
// single-slot channel outputs, each with its own ready.
interface bus_demux_8ch32_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] databus;
    logic [2:0]        sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic [7:0]        out_valid;
    logic [7:0]        out_ready;
    logic [3:0]        pending;

    modport slave (
        input  databus, sel, in_valid, out_ready,
        output in_ready, D0, D1, D2, D3, D4, D5, D6, D7, out_valid, pending
    );

    modport master (
        output databus, sel, in_valid, out_ready,
        input  in_ready, D0, D1, D2, D3, D4, D5, D6, D7, out_valid, pending
    );
endinterface

// File: rtl/bus_demux_8ch32.sv
// 1-to-8 demultiplexer with one holding slot per channel; a channel accepts
// a new word when empty or while its current word is being drained.
module bus_demux_8ch32_lane #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              valid_nxt_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    // Load wins over drain so a same-cycle drain+load keeps the slot full.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~drain_i;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;
endmodule

module bus_demux_8ch32 #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_demux_8ch32_if.slave      bus
);
    localparam int NUM_CH = 8;

    logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0]             ch_valid_nxt;
    logic [NUM_CH-1:0]             load;
    logic                          fire;
    logic [3:0]                    pending_q, pending_d;

    // Ready depends only on the selected slot, never on in_valid.
    assign bus.in_ready = ~ch_valid[bus.sel] | bus.out_ready[bus.sel];
    assign fire         = bus.in_valid & bus.in_ready;

    always_comb begin
        load = '0;
        load[bus.sel] = fire;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        bus_demux_8ch32_lane #(.DATA_W(DATA_W)) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (load[c]),
            .drain_i     (bus.out_ready[c]),
            .data_i      (bus.databus),
            .data_o      (ch_data[c]),
            .valid_o     (ch_valid[c]),
            .valid_nxt_o (ch_valid_nxt[c])
        );
    end

    always_comb begin
        pending_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            pending_d = pending_d + {3'd0, ch_valid_nxt[c]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign bus.out_valid = ch_valid;
    assign bus.pending   = pending_q;
    assign bus.D0 = ch_data[0];
    assign bus.D1 = ch_data[1];
    assign bus.D2 = ch_data[2];
    assign bus.D3 = ch_data[3];
    assign bus.D4 = ch_data[4];
    assign bus.D5 = ch_data[5];
    assign bus.D6 = ch_data[6];
    assign bus.D7 = ch_data[7];
endmodule

// File: tb/tb_bus_demux_8ch32.sv
// Directed vector table plus hand sequences and a random scoreboard run.
module tb_bus_demux_8ch32;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bus_demux_8ch32_if #(.DATA_W(32)) bif ();
    bus_demux_8ch32 #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    always #5 clk = ~clk;

    logic [7:0][31:0] dv;
    assign dv = {bif.D7, bif.D6, bif.D5, bif.D4, bif.D3, bif.D2, bif.D1, bif.D0};

    typedef struct {
        logic        iv;
        logic [2:0]  sel;
        logic [31:0] data;
        logic [7:0]  ordy;
        logic        e_rdy;
        logic [7:0]  e_ov;
        logic [3:0]  e_pend;
        int          e_ch;
        logic [31:0] e_d;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] s, input logic [31:0] d, input logic [7:0] r);
        bif.in_valid  = iv;
        bif.sel       = s;
        bif.databus   = d;
        bif.out_ready = r;
    endtask

    // Inputs are applied 1 time unit after a rising edge; sample just before the next.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[8][$];
    logic [7:0]  mval;
    logic [3:0]  mcnt;

    initial begin
        vt[0] = '{1, 3, 32'hA5A5_0003, 8'h00, 1, 8'h08, 1, 3, 32'hA5A5_0003};
        vt[1] = '{1, 3, 32'h1111_1111, 8'h00, 0, 8'h08, 1, 3, 32'hA5A5_0003};
        vt[2] = '{1, 5, 32'h5555_0005, 8'h00, 1, 8'h28, 2, 5, 32'h5555_0005};
        vt[3] = '{1, 6, 32'hDEAD_0001, 8'h00, 1, 8'h68, 3, 6, 32'hDEAD_0001};
        vt[4] = '{1, 6, 32'hDEAD_0002, 8'h40, 1, 8'h68, 3, 6, 32'hDEAD_0002};
        vt[5] = '{0, 3, 32'h0000_0000, 8'h08, 1, 8'h60, 2, 3, 32'hA5A5_0003};
        vt[6] = '{0, 0, 32'h0000_0000, 8'h01, 1, 8'h60, 2, 0, 32'h0000_0000};
        vt[7] = '{1, 5, 32'h7777_7777, 8'h60, 1, 8'h20, 1, 5, 32'h7777_7777};
        vt[8] = '{1, 2, 32'h2222_0002, 8'h20, 1, 8'h04, 1, 2, 32'h2222_0002};
        vt[9] = '{0, 2, 32'h0000_0000, 8'h00, 0, 8'h04, 1, 2, 32'h2222_0002};

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        chk("rst_out_valid", {24'd0, bif.out_valid}, 0);
        chk("rst_pending", {28'd0, bif.pending}, 0);
        chk("rst_in_ready", {31'd0, bif.in_ready}, 1);
        for (int c = 0; c < 8; c++) chk($sformatf("rst_D%0d", c), dv[c], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].iv, vt[i].sel, vt[i].data, vt[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, bif.in_ready}, {31'd0, vt[i].e_rdy});
            tick();
            chk($sformatf("v%0d_out_valid", i), {24'd0, bif.out_valid}, {24'd0, vt[i].e_ov});
            chk($sformatf("v%0d_pending", i), {28'd0, bif.pending}, {28'd0, vt[i].e_pend});
            chk($sformatf("v%0d_D%0d", i, vt[i].e_ch), dv[vt[i].e_ch], vt[i].e_d);
            if (i == 0)
                for (int c = 0; c < 8; c++)
                    if (c != 3) chk($sformatf("v0_D%0d_zero", c), dv[c], 0);
        end

        // Drain what is left, then fill all eight and drain them in one cycle.
        drive(0, 0, 0, 8'hFF);
        tick();
        chk("empty_out_valid", {24'd0, bif.out_valid}, 0);
        for (int c = 0; c < 8; c++) begin
            drive(1, 3'(c), 32'hC0DE_0000 + 32'(c), 8'h00);
            tick();
        end
        chk("fill_pending", {28'd0, bif.pending}, 8);
        chk("fill_out_valid", {24'd0, bif.out_valid}, 8'hFF);
        drive(0, 0, 0, 8'hFF);
        tick();
        chk("drain_out_valid", {24'd0, bif.out_valid}, 0);
        chk("drain_pending", {28'd0, bif.pending}, 0);
        for (int c = 0; c < 8; c++)
            chk($sformatf("drain_hold_D%0d", c), dv[c], 32'hC0DE_0000 + 32'(c));

        // Async reset between edges with channels 0,2,4 full.
        for (int c = 0; c <= 4; c += 2) begin
            drive(1, 3'(c), 32'hBEEF_0000 + 32'(c), 8'h00);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("pre_rst_out_valid", {24'd0, bif.out_valid}, 8'h15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {24'd0, bif.out_valid}, 0);
        chk("async_pending", {28'd0, bif.pending}, 0);
        chk("async_in_ready", {31'd0, bif.in_ready}, 1);
        for (int c = 0; c < 8; c++) chk($sformatf("async_D%0d", c), dv[c], 0);
        drive(1, 1, 32'h0BAD_0001, 0);
        @(posedge clk);
        #1;
        chk("no_fire_in_reset", {24'd0, bif.out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 32'h600D_0001, 0);
        @(posedge clk);
        #1;
        chk("first_accept_ov", {24'd0, bif.out_valid}, 8'h02);
        chk("first_accept_D1", dv[1], 32'h600D_0001);
        drive(0, 0, 0, 8'hFF);
        tick();

        // Random traffic against per-channel depth-1 reference queues.
        for (int n = 0; n < 10000; n++) begin
            logic        iv;
            logic [2:0]  s;
            logic [31:0] d;
            logic [7:0]  r;
            logic        erdy;
            iv = 1'($urandom);
            s  = 3'($urandom);
            d  = $urandom;
            r  = 8'($urandom);
            drive(iv, s, d, r);
            #1;
            erdy = (q[s].size() == 0) || r[s];
            chk("rnd_in_ready", {31'd0, bif.in_ready}, {31'd0, erdy});
            for (int c = 0; c < 8; c++)
                if (r[c] && q[c].size() != 0)
                    chk($sformatf("rnd_deliver_D%0d", c), dv[c], q[c].pop_front());
            if (iv && erdy) q[s].push_back(d);
            tick();
            mval = '0;
            mcnt = '0;
            for (int c = 0; c < 8; c++) begin
                mval[c] = (q[c].size() != 0);
                mcnt    = mcnt + 4'(q[c].size());
            end
            chk("rnd_out_valid", {24'd0, bif.out_valid}, {24'd0, mval});
            chk("rnd_pending", {28'd0, bif.pending}, {28'd0, mcnt});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
